// File: rtl/dso_pkg.sv
// Shared types and constants for the DSO acquisition path.
package dso_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic TRIG_SRC_1 = 1'b0;
  localparam logic TRIG_SRC_2 = 1'b1;
  localparam logic EDGE_POS   = 1'b1;
  localparam logic EDGE_NEG   = 1'b0;

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} cap_state_t;

endpackage

// File: rtl/trig_detect.sv
// Trigger front end: synchronizes both comparators, selects one, and flags the chosen edge.
module trig_detect
  import dso_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic trig1,
  input  logic trig2,
  input  logic trig_src,
  input  logic trig_edge,
  output logic trig_evt
);

  logic [1:0] meta_q, sync_q;
  logic       lvl, lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      meta_q <= {trig2, trig1};
      sync_q <= meta_q;
      lvl_q  <= lvl;
    end
  end

  assign lvl      = (trig_src == TRIG_SRC_1) ? sync_q[0] : sync_q[1];
  assign trig_evt = (trig_edge == EDGE_NEG) ? (~lvl & lvl_q) : (lvl & ~lvl_q);

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: ADC/RAM clocks, decimated circular capture around a trigger,
// and oldest-first readback of the finished record.
module capture_ctrl #(
  parameter int unsigned ADDR_W = $clog2(dso_pkg::DEPTH),
  parameter int unsigned DEC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig1,
  input  logic              trig2,
  input  logic              trig_src,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decim,
  input  logic              arm,
  input  logic              abort,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic              adc_clk,
  output logic              rclk,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_vld,
  output logic              triggered,
  output logic              done
);

  localparam int unsigned     CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};

  dso_pkg::cap_state_t state_q, state_d;

  logic              adc_clk_q, tick;
  logic              src_q, edge_q;
  logic [ADDR_W-1:0] pos_q, wptr_q, addr_q;
  logic [DEC_W-1:0]  decim_q, dec_cnt_q;
  logic [CntW-1:0]   cnt_q;
  logic              en_q, we_q, rd_vld_q, triggered_q, done_q;
  logic [1:0]        rd_st_q;
  logic              trig_evt, capturing, pre_full, post_full;
  logic              wr_ok, wr_stb, trig_acc, rd_acc;

  trig_detect u_trig_detect (
    .clk      (clk),
    .rst      (rst),
    .trig1    (trig1),
    .trig2    (trig2),
    .trig_src (src_q),
    .trig_edge(edge_q),
    .trig_evt (trig_evt)
  );

  // RAM strobes launch on the edge where rclk falls so they are stable at the next rclk rise.
  assign tick      = ~adc_clk_q;
  assign capturing = state_q inside {dso_pkg::PRE, dso_pkg::ARMED, dso_pkg::POST};
  assign pre_full  = (state_q == dso_pkg::PRE) && (cnt_q == DepthCnt - {1'b0, pos_q});
  assign post_full = (state_q == dso_pkg::POST) && (cnt_q == {1'b0, pos_q});
  assign wr_ok     = capturing && !post_full && !arm && !abort;
  assign wr_stb    = tick && wr_ok && (dec_cnt_q == decim_q);
  assign trig_acc  = (state_q == dso_pkg::ARMED) && trig_evt && !arm && !abort;
  assign rd_acc    = rd_en && (state_q == dso_pkg::DONE) && (rd_st_q == 2'd0) && !arm && !abort;

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = dso_pkg::IDLE;
    end else if (arm) begin
      state_d = dso_pkg::PRE;
    end else begin
      unique case (state_q)
        dso_pkg::PRE:   if (pre_full)  state_d = dso_pkg::ARMED;
        dso_pkg::ARMED: if (trig_evt)  state_d = dso_pkg::POST;
        dso_pkg::POST:  if (post_full) state_d = dso_pkg::DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= dso_pkg::IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_clk_q   <= 1'b0;
      src_q       <= 1'b0;
      edge_q      <= 1'b0;
      pos_q       <= '0;
      decim_q     <= '0;
      dec_cnt_q   <= '0;
      wptr_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      rd_st_q     <= 2'd0;
      rd_vld_q    <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      adc_clk_q <= ~adc_clk_q;
      rd_vld_q  <= (rd_st_q == 2'd2) && !abort && !arm;
      if (abort || arm) begin
        en_q        <= 1'b0;
        we_q        <= 1'b0;
        rd_st_q     <= 2'd0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
        if (!abort) begin
          src_q     <= trig_src;
          edge_q    <= trig_edge;
          pos_q     <= trig_pos;
          decim_q   <= decim;
          dec_cnt_q <= '0;
          cnt_q     <= '0;
        end
      end else begin
        if (tick && wr_ok) dec_cnt_q <= (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + 1'b1;
        if (wr_stb) begin
          en_q   <= 1'b1;
          we_q   <= 1'b1;
          addr_q <= wptr_q;
          wptr_q <= wptr_q + 1'b1;
          if (state_q != dso_pkg::ARMED) cnt_q <= cnt_q + 1'b1;
        end else if (rd_acc) begin
          en_q    <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= wptr_q + rd_idx;
          rd_st_q <= 2'd1;
        end else if (rd_st_q == 2'd3 || (tick && rd_st_q == 2'd0)) begin
          en_q <= 1'b0;
          we_q <= 1'b0;
        end
        // Read strobe is held across one full rclk period; state 3 releases it.
        if (rd_st_q != 2'd0) rd_st_q <= rd_st_q + 2'd1;
        if (trig_acc) begin
          cnt_q       <= '0;
          triggered_q <= 1'b1;
        end
        if (post_full) done_q <= 1'b1;
      end
    end
  end

  assign adc_clk   = adc_clk_q;
  assign rclk      = ~(adc_clk_q | rst);
  assign en        = en_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign rd_vld    = rd_vld_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule
